// File: rtl/bsc_param_if.sv
// ----------------------------------------------------------------------------
// bsc_param_if
// Signal bundle between the start-bit detector / receive shift register and
// the bit-sampling counter.
//   enable     : run request from the start detector (master -> slave)
//   rx         : synchronised serial input line         (master -> slave)
//   sr_clk     : one-cycle sample strobe                 (slave -> master)
//   bit_val    : rx value captured for the current bit   (slave -> master)
//   bit_idx    : index of the current bit in the frame   (slave -> master)
//   frame_done : one-cycle pulse after the last bit      (slave -> master)
// FRAME_BITS must match the value given to bsc_param so bit_idx widths agree.
// ----------------------------------------------------------------------------
interface bsc_param_if #(
    parameter int FRAME_BITS = 10,
    parameter int BW         = $clog2(FRAME_BITS)
);
    logic          enable;
    logic          rx;
    logic          sr_clk;
    logic          bit_val;
    logic [BW-1:0] bit_idx;
    logic          frame_done;

    modport master (
        output enable, rx,
        input  sr_clk, bit_val, bit_idx, frame_done
    );

    modport slave (
        input  enable, rx,
        output sr_clk, bit_val, bit_idx, frame_done
    );
endinterface

// File: rtl/bsc_param.sv
// ----------------------------------------------------------------------------
// bsc_param
// Parametrised bit-sampling counter for the serial receive path. Divides the
// oversampled clock into bit periods of OSR cycles, emits a one-cycle sample
// strobe at a configurable phase of each bit, captures rx at that phase,
// counts bits within a frame and pulses frame_done after the last bit.
//
// Ports:
//   clk   : oversampled system clock
//   reset : synchronous, active-high reset
//   bus   : bsc_param_if.slave (enable, rx in; sr_clk, bit_val, bit_idx,
//           frame_done out, all outputs registered)
//
// Optional feature macro: BSC_MAJORITY_VOTE_EN
//   Defined   : rx sampled at SAMPLE_AT-1, SAMPLE_AT, SAMPLE_AT+1; bit_val is
//               the majority of the three, strobe moves to SAMPLE_AT+1.
//   Undefined : single sample at SAMPLE_AT.
// ----------------------------------------------------------------------------
module bsc_param #(
    parameter int OSR        = 16,
    parameter int SAMPLE_AT  = 8,
    parameter int FRAME_BITS = 10,
    parameter int PW         = $clog2(OSR),
    parameter int BW         = $clog2(FRAME_BITS)
) (
    input  logic        clk,
    input  logic        reset,
    bsc_param_if.slave  bus
);

    // Elaboration-time legality checks.
    if (OSR < 4 || OSR > 256) begin : g_bad_osr
        $error("bsc_param: OSR must be in 4..256");
    end
    if (FRAME_BITS < 2 || FRAME_BITS > 64) begin : g_bad_frame
        $error("bsc_param: FRAME_BITS must be in 2..64");
    end
`ifdef BSC_MAJORITY_VOTE_EN
    if (SAMPLE_AT < 1 || SAMPLE_AT > OSR - 2) begin : g_bad_sample
        $error("bsc_param: SAMPLE_AT must be in 1..OSR-2 with majority vote");
    end
`else
    if (SAMPLE_AT < 0 || SAMPLE_AT > OSR - 1) begin : g_bad_sample
        $error("bsc_param: SAMPLE_AT must be in 0..OSR-1");
    end
`endif

    localparam logic [PW-1:0] LAST_PH  = PW'(OSR - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
`ifdef BSC_MAJORITY_VOTE_EN
    localparam logic [PW-1:0] VOTE_LO  = PW'(SAMPLE_AT - 1);
    localparam logic [PW-1:0] VOTE_MID = PW'(SAMPLE_AT);
    localparam logic [PW-1:0] STB_PH   = PW'(SAMPLE_AT + 1);
`else
    localparam logic [PW-1:0] STB_PH   = PW'(SAMPLE_AT);
`endif

    logic [PW-1:0] r_phase;
    logic [BW-1:0] r_bit_idx;
    logic          r_sr_clk;
    logic          r_bit_val;
    logic          r_frame_done;

    logic          w_phase_last;
    logic          w_strobe;

    // Explicit wrap at OSR-1 keeps non-power-of-two OSR out of unused codes.
    assign w_phase_last = (r_phase == LAST_PH);
    assign w_strobe     = (r_phase == STB_PH);

`ifdef BSC_MAJORITY_VOTE_EN
    // The first two vote samples are registered; the third is the live rx on
    // the strobe edge, so bit_val settles on the same edge sr_clk rises.
    logic [1:0] r_vote;
    logic       w_majority;

    assign w_majority = (r_vote[0] & r_vote[1])
                      | (r_vote[0] & bus.rx)
                      | (r_vote[1] & bus.rx);
`endif

    // NOTE: every register here is assigned with <= so all decisions within
    // one edge see the pre-edge phase and bit index, never a half-updated one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase      <= '0;
            r_bit_idx    <= '0;
            r_sr_clk     <= 1'b0;
            r_frame_done <= 1'b0;
            // NOTE: bit_val resets to 1 (idle line level), not 0, so a
            // consumer peeking before the first strobe sees a mark.
            r_bit_val    <= 1'b1;
`ifdef BSC_MAJORITY_VOTE_EN
            r_vote       <= 2'b11;
`endif
        end else if (!bus.enable) begin
            // Abort: clear timing state, hold the last captured bit.
            r_phase      <= '0;
            r_bit_idx    <= '0;
            r_sr_clk     <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef BSC_MAJORITY_VOTE_EN
            r_vote       <= 2'b11;
`endif
        end else begin
            r_phase  <= w_phase_last ? '0 : r_phase + 1'b1;
            r_sr_clk <= w_strobe;

`ifdef BSC_MAJORITY_VOTE_EN
            if (r_phase == VOTE_LO)  r_vote[0] <= bus.rx;
            if (r_phase == VOTE_MID) r_vote[1] <= bus.rx;
            if (w_strobe)            r_bit_val <= w_majority;
`else
            if (w_strobe)            r_bit_val <= bus.rx;
`endif

            if (w_phase_last) begin
                if (r_bit_idx == LAST_BIT) begin
                    r_bit_idx    <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_bit_idx    <= r_bit_idx + 1'b1;
                    r_frame_done <= 1'b0;
                end
            end else begin
                r_frame_done <= 1'b0;
            end
        end
    end

    assign bus.sr_clk     = r_sr_clk;
    assign bus.bit_val    = r_bit_val;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bsc_param.sv
// ----------------------------------------------------------------------------
// tb_bsc_param
// Drives two bsc_param instances (defaults, and OSR=6/SAMPLE_AT=3/
// FRAME_BITS=2) with the same reset/enable/rx stimulus. A reference model
// derives expected outputs from the number of run cycles since the last
// clear; expectations are queued at stimulus time and popped by a monitor.
// ----------------------------------------------------------------------------
module tb_bsc_param;

`ifdef BSC_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    typedef struct {
        bit sr;
        bit bv;
        int idx;
        bit fd;
    } exp_t;

    logic clk;
    logic reset;

    bsc_param_if #(.FRAME_BITS(10)) bus0 ();
    bsc_param_if #(.FRAME_BITS(2))  bus1 ();

    bsc_param #(.OSR(16), .SAMPLE_AT(8), .FRAME_BITS(10)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    bsc_param #(.OSR(6), .SAMPLE_AT(3), .FRAME_BITS(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    bit   sq0[$];
    bit   sq1[$];

    // Model state per instance: run cycles since clear, current bit value,
    // rx seen at each phase of the current bit.
    int t_run [2];
    bit m_bv  [2];
    bit samp  [2][256];

    function automatic int osr_of(input int k);
        return (k == 0) ? 16 : 6;
    endfunction
    function automatic int sa_of(input int k);
        return (k == 0) ? 8 : 3;
    endfunction
    function automatic int fb_of(input int k);
        return (k == 0) ? 10 : 2;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after the coming edge, from the frame arithmetic.
    task automatic model(input int k, input bit rst, input bit en, input bit r,
                         output exp_t e);
        int osr;
        int fb;
        int stb;
        int ph;
        osr = osr_of(k);
        fb  = fb_of(k);
        stb = sa_of(k) + VOTE;
        if (rst) begin
            t_run[k] = 0;
            m_bv[k]  = 1'b1;
            e = '{sr: 1'b0, bv: 1'b1, idx: 0, fd: 1'b0};
        end else if (!en) begin
            t_run[k] = 0;
            e = '{sr: 1'b0, bv: m_bv[k], idx: 0, fd: 1'b0};
        end else begin
            ph = t_run[k] % osr;
            samp[k][ph] = r;
            if (ph == stb) begin
                if (VOTE == 1)
                    m_bv[k] = ((int'(samp[k][stb-2]) + int'(samp[k][stb-1]) + int'(r)) >= 2);
                else
                    m_bv[k] = r;
            end
            e.sr  = (ph == stb);
            e.bv  = m_bv[k];
            e.idx = ((t_run[k] + 1) / osr) % fb;
            e.fd  = ((t_run[k] % (osr * fb)) == (osr * fb - 1));
            t_run[k]++;
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit r);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        bus0.enable = en;
        bus0.rx     = r;
        bus1.enable = en;
        bus1.rx     = r;
        model(0, rst, en, r, e);
        q0.push_back(e);
        if (e.sr) sq0.push_back(e.bv);
        model(1, rst, en, r, e);
        q1.push_back(e);
        if (e.sr) sq1.push_back(e.bv);
    endtask

    // Monitor: checks each instance #1 after every active edge.
    exp_t m_e;
    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) begin
            m_e = q0.pop_front();
            check("d0_sr_clk",     int'(bus0.sr_clk),     int'(m_e.sr));
            check("d0_bit_val",    int'(bus0.bit_val),    int'(m_e.bv));
            check("d0_bit_idx",    int'(bus0.bit_idx),    m_e.idx);
            check("d0_frame_done", int'(bus0.frame_done), int'(m_e.fd));
            if (bus0.sr_clk) begin
                if (sq0.size() == 0) check("d0_unexpected_strobe", 1, 0);
                else                 check("d0_strobe_bit", int'(bus0.bit_val), int'(sq0.pop_front()));
            end
        end
        if (q1.size() > 0) begin
            m_e = q1.pop_front();
            check("d1_sr_clk",     int'(bus1.sr_clk),     int'(m_e.sr));
            check("d1_bit_val",    int'(bus1.bit_val),    int'(m_e.bv));
            check("d1_bit_idx",    int'(bus1.bit_idx),    m_e.idx);
            check("d1_frame_done", int'(bus1.frame_done), int'(m_e.fd));
            if (bus1.sr_clk) begin
                if (sq1.size() == 0) check("d1_unexpected_strobe", 1, 0);
                else                 check("d1_strobe_bit", int'(bus1.bit_val), int'(sq1.pop_front()));
            end
        end
    end

    initial begin
        bit r;
        bit rst;
        bit en;
        reset       = 1'b1;
        bus0.enable = 1'b0;
        bus0.rx     = 1'b1;
        bus1.enable = 1'b0;
        bus1.rx     = 1'b1;

        // Reset held with enable high and rx low.
        repeat (3) step(1'b1, 1'b1, 1'b0);

        // Strobe timing, data capture and two full frames.
        for (int e = 0; e < 330; e++) begin
            if (e < 16)      r = 1'b0;
            else if (e < 32) r = 1'b1;
            else             r = 1'($urandom_range(0, 1));
            if (VOTE == 1 && e == 8) r = 1'b1;
            step(1'b0, 1'b1, r);
        end

        // Abort mid-frame: enable low on edges 40..44, restart at 45.
        step(1'b1, 1'b0, 1'b1);
        for (int e = 0; e < 90; e++) begin
            en = !(e >= 40 && e < 45);
            step(1'b0, en, 1'($urandom_range(0, 1)));
        end

        // Reset mid-frame.
        for (int e = 0; e < 50; e++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Random traffic with rare enable drops and resets.
        for (int e = 0; e < 4000; e++) begin
            rst = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 399) != 0);
            step(rst, en, 1'($urandom_range(0, 1)));
        end

        step(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        check("q0_drained",  q0.size(),  0);
        check("q1_drained",  q1.size(),  0);
        check("sq0_drained", sq0.size(), 0);
        check("sq1_drained", sq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsc_param.md
Name: bsc_param

Overview:
- Parametrised bit-sampling counter for the serial receive path.
- Divides the oversampled clock into bit periods and emits a one-cycle sample strobe at a configurable phase of each bit.
- Captures the rx line value at that phase, counts bits within a frame, and pulses frame_done at the end of each frame.
- Sits between the start-bit detector (which drives enable) and the receive shift register (which consumes sr_clk and bit_val).

Parameters:
- OSR, 16, clocks per bit period; legal range 4..256.
- SAMPLE_AT, 8, phase (0..OSR-1) at which the bit is sampled.
- FRAME_BITS, 10, bits per frame including start and stop bits; legal range 2..64.
- PW, $clog2(OSR), phase counter width; derived, do not override.
- BW, $clog2(FRAME_BITS), bit index width; derived, do not override.

Ports:
- clk  in  1  system clock (oversampled rate).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request from start detector; low clears the block.
- rx  in  1  synchronised serial input line.
- sr_clk  out  1  one-cycle sample strobe, registered.
- bit_val  out  1  rx value captured for the current bit, registered.
- bit_idx  out  BW  index of the current bit within the frame.
- frame_done  out  1  one-cycle pulse after the last bit period of a frame.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset. All state changes on posedge clk.
- Priority: reset > enable low > run.
- Reset values: phase=0, bit_idx=0, sr_clk=0, frame_done=0, bit_val=1 (idle line high).
- enable low (no reset): phase=0, bit_idx=0, sr_clk=0, frame_done=0; bit_val holds.
- Run (enable high), evaluated on the pre-edge phase value:
  - phase <= (phase==OSR-1) ? 0 : phase+1.
  - sr_clk <= (phase==SAMPLE_AT). Strobe is high for exactly one cycle per bit, latency 1 clock after phase==SAMPLE_AT.
  - bit_val <= rx when phase==SAMPLE_AT (same edge sr_clk rises); held otherwise.
  - On phase==OSR-1:
    - if bit_idx==FRAME_BITS-1: bit_idx <= 0 and frame_done <= 1.
    - else: bit_idx <= bit_idx+1 and frame_done <= 0.
  - At all other phases, frame_done <= 0.
- Back-to-back frames: with enable held, the next frame starts immediately at phase 0, bit_idx 0, with no gap cycle.
- Frame timing: first edge with enable high sees phase 0. A full frame spans OSR*FRAME_BITS edges.
- Enable dropping mid-bit aborts the frame with no frame_done. Re-enable restarts from phase 0.
- Reset mid-frame behaves identically to an enable drop, plus bit_val returns to 1.
- Non-power-of-two OSR: the counter wraps explicitly at OSR-1; it must never run through the unused codes.

Optional Feature:
- Macro: BSC_MAJORITY_VOTE_EN.
- Defined:
  - rx is sampled at phases SAMPLE_AT-1, SAMPLE_AT and SAMPLE_AT+1.
  - bit_val <= majority of the three samples, on the edge where phase==SAMPLE_AT+1.
  - sr_clk <= (phase==SAMPLE_AT+1), so the strobe moves one cycle later.
  - Requires 1 <= SAMPLE_AT <= OSR-2; elaboration error otherwise.
  - The three vote samples are cleared to 1 by reset and by enable low.
- Undefined: single sample at SAMPLE_AT as described above; no vote registers.

Test Plan:
- Reset: reset=1 for 3 cycles with enable=1 and rx=0 -> sr_clk=0, frame_done=0, bit_idx=0, bit_val=1 throughout.
- Strobe timing: defaults, enable=1 from edge 0 -> sr_clk high only after edges 8, 24, 40, ...; bit_idx becomes 1 after edge 15 and 2 after edge 31.
- Full frame: enable held 330 cycles -> exactly 10 strobes per frame; frame_done high only after edges 159 and 319; bit_idx reads 0 after edge 159.
- Data capture: rx=0 for edges 0-15, 1 for edges 16-31 -> bit_val=0 after edge 8, 1 after edge 24. With BSC_MAJORITY_VOTE_EN and rx glitch high only at edge 8 -> bit_val=0 after edge 9.
- Abort: enable low at edge 40, high again from edge 45 -> after edge 40 phase=0, bit_idx=0 and sr_clk=0; no frame_done; next strobe after edge 53.
- Alternate parameters: OSR=6, SAMPLE_AT=3, FRAME_BITS=2 -> strobes after edges 3, 9, 15, 21; frame_done after edges 11 and 23; phase never exceeds 5.
